// File: rtl/dmem_port.sv
// dmem_port: data-memory responder for the CPU load/store path.
// Accepts one access at a time over a req/ready handshake, waits a
// programmable number of cycles, then answers with a single-cycle ack.
// Misaligned or out-of-range accesses are flagged with err and not performed.
module dmem_port #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        take;    // access accepted on this edge
    logic        fire;    // this edge enters RESP: commit write / load rdata

    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        err_q;

    // Operands of the access that completes on this edge. With zero latency
    // the access completes on its acceptance edge, so the live inputs are used
    // because nothing has been latched yet.
    logic          a_we;
    logic [31:0]   a_addr, a_wdata;
    logic [3:0]    a_be;
    logic          a_err;
    logic [AW-1:0] a_idx;

    logic [31:0] mem [DEPTH_WORDS];

    // Operand select, range/alignment check and word index
    always_comb begin
        a_we    = we_q;
        a_addr  = addr_q;
        a_wdata = wdata_q;
        a_be    = be_q;
        if (state == IDLE) begin
            a_we    = we;
            a_addr  = addr;
            a_wdata = wdata;
            a_be    = be;
        end
        // DEPTH_WORDS is a power of two, so "index >= depth" is any bit set
        // above the index field.
        a_err = (a_addr[1:0] != 2'b00) || (a_addr[31:AW+2] != '0);
        a_idx = a_addr[AW+1:2];
    end

    // Next-state and wait counter. The counter is loaded with LATENCY at
    // acceptance and counted down in WAIT; RESP is entered on the edge after
    // it has reached zero, which spaces ack LATENCY+1 edges after acceptance.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        take     = 1'b0;
        fire     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    take   = 1'b1;
                    cnt_nx = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_nx = RESP;
                        fire     = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nx = RESP;
                    fire     = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Request latch; later input changes do not reach the in-flight access
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else if (take) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            be_q    <= be;
        end
    end

    // Response registers: err and read data captured when entering RESP
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
            rdata <= 32'd0;
        end else if (fire) begin
            err_q <= a_err;
            if (!a_we) rdata <= a_err ? 32'd0 : mem[a_idx];
        end
    end

    // Storage array: not reset; reset blocks a write that lands on its edge
    always_ff @(posedge clk) begin
        if (!reset && fire && a_we && !a_err) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

    assign ready = (state == IDLE);
    assign ack   = (state == RESP);
    assign err   = ack & err_q;

endmodule
